// File: rtl/serial_mag_comp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | serial_mag_comp                                                            |
// | MSB-first digit-serial eq/lt/gt comparator, unsigned or two's complement.  |
// | Optional EARLY_EXIT_EN macro: finish on the first differing digit.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module serial_mag_comp #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_md,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             lt,
  output logic             gt
);

  localparam int C_N  = WIDTH / DIGIT;
  localparam int C_CW = $clog2(C_N) + 1;
  localparam logic [C_CW-1:0]  C_LAST = C_CW'(C_N - 1);
  localparam logic [WIDTH-1:0] C_MSB  = WIDTH'(1) << (WIDTH - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [C_CW-1:0]  r_cnt;
  logic             r_decided;
  logic             r_lt_rec;
  logic             r_gt_rec;
  logic             r_done;
  logic             r_eq;
  logic             r_lt;
  logic             r_gt;

  logic [WIDTH-1:0] w_flip;
  logic [DIGIT-1:0] w_da;
  logic [DIGIT-1:0] w_db;
  logic             w_diff;
  logic             w_dlt;
  logic             w_lt_fin;
  logic             w_gt_fin;
  logic             w_finish;

  // Inverting the sign bit maps two's-complement order onto unsigned order.
  assign w_flip   = signed_md ? C_MSB : '0;
  assign w_da     = r_a_sh[WIDTH-1 -: DIGIT];
  assign w_db     = r_b_sh[WIDTH-1 -: DIGIT];
  assign w_diff   = !r_decided && (w_da != w_db);
  assign w_dlt    = (w_da < w_db);
  assign w_lt_fin = r_decided ? r_lt_rec : (w_diff & w_dlt);
  assign w_gt_fin = r_decided ? r_gt_rec : (w_diff & ~w_dlt);

`ifdef EARLY_EXIT_EN
  assign w_finish = (r_cnt == C_LAST) || w_diff;
`else
  assign w_finish = (r_cnt == C_LAST);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_finish) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a_sh    <= '0;
      r_b_sh    <= '0;
      r_cnt     <= '0;
      r_decided <= 1'b0;
      r_lt_rec  <= 1'b0;
      r_gt_rec  <= 1'b0;
      r_done    <= 1'b0;
      r_eq      <= 1'b0;
      r_lt      <= 1'b0;
      r_gt      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (start) begin
          r_a_sh    <= a ^ w_flip;
          r_b_sh    <= b ^ w_flip;
          r_cnt     <= '0;
          r_decided <= 1'b0;
          r_lt_rec  <= 1'b0;
          r_gt_rec  <= 1'b0;
        end
      end else begin
        r_a_sh <= r_a_sh << DIGIT;
        r_b_sh <= r_b_sh << DIGIT;
        r_cnt  <= r_cnt + 1'b1;
        // Only the first differing digit is recorded; later digits are ignored.
        if (w_diff) begin
          r_decided <= 1'b1;
          r_lt_rec  <= w_dlt;
          r_gt_rec  <= ~w_dlt;
        end
        if (w_finish) begin
          r_done <= 1'b1;
          r_eq   <= !(r_decided || w_diff);
          r_lt   <= w_lt_fin;
          r_gt   <= w_gt_fin;
        end
      end
    end
  end

  always_comb begin
    busy = (r_state == S_RUN);
    done = r_done;
    eq   = r_eq;
    lt   = r_lt;
    gt   = r_gt;
  end

endmodule
`default_nettype wire
